int_sequencer: RTL and testbench
================================

// Module: int_sequencer
// PURPOSE
//  Interrupt sequencer for the 16-bit pipeline. Latches hardware interrupt edges and software INT requests,
//  arbitrates among them, picks a safe ID-stage boundary, and drives the hazard unit's interception/EPC inputs.
//  Redirects the PC to the handler vector, then back to EPC on ERET. Sits between the I/O sources,
//  the decoder and the hazard unit.
// PARAMETERS
//  NSRC      4         number of hardware interrupt sources (2..8)
//  VEC_BASE  16'h0008  handler entry PC driven on vector_o
// PORTS
//  CLK            in   1     system clock, rising edge
//  RST            in   1     asynchronous reset, active-high
//  irq_i          in   NSRC  level hardware requests; a rising edge makes the source pending
//  mask_we_i      in   1     write strobe for the enable register
//  mask_d_i       in   NSRC  enable-register write data (1 = enabled)
//  sw_int_i       in   1     INT instruction valid in ID
//  sw_code_i      in   4     INT immediate
//  id_valid_i     in   1     ID holds a real (non-bubble) instruction
//  stall_i        in   1     hazard unit load-use stall this cycle
//  br_in_ex_i     in   1     EX holds a branch/jump, so ID is a delay slot
//  pc_id_i        in   16    PC of the instruction in ID
//  eret_i         in   1     ERET valid in EX
//  interception_o out  1     one-cycle pulse to hazard interception_i
//  epc_o          out  16    saved PC, to hazard epc_i and the PC mux
//  cause_o        out  5     [4]=software, [3:0]=source index or INT code
//  vector_o       out  16    constant VEC_BASE
//  pc_sel_o       out  2     00 normal, 01 vector, 10 EPC
//  ack_o          out  NSRC  one-hot one-cycle acknowledge to the serviced source
//  busy_o         out  1     state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; pending, enable, epc_o, cause_o, ack_o = 0; interception_o = 0; pc_sel_o = 00;
//   prior irq_i = 0. Takes effect asynchronously at any state, including mid-sequence.
//  Edge detect: pending[i] sets on irq_i[i] & ~irq_q[i].
//   pending[i] clears on ack_o[i], unless a new edge arrives in the same cycle (set wins).
//  Eligible: (pending & enable) != 0, or sw_int_i. Software requests ignore the enable register
//   and win over hardware.
//  Safe point: id_valid_i & ~stall_i & ~br_in_ex_i. Without a safe point, requests wait.
//  FSM states:
//   IDLE:    eligible & safe point -> TAKE. Capture epc_o <= pc_id_i, capture cause_o,
//            latch the winner index.
//   TAKE:    interception_o = 1 (hazard flushes IF/ID/EX). ack_o[winner] = 1 for a hardware win.
//            -> VECTOR.
//   VECTOR:  pc_sel_o = 01 for exactly 1 cycle. -> HANDLER.
//   HANDLER: no new take; pending requests keep accumulating. eret_i -> RETURN.
//   RETURN:  pc_sel_o = 10 for 1 cycle. -> IDLE.
//  Minimum spacing between two TAKE cycles is 5 cycles. The earliest re-take is the cycle after RETURN.
//  eret_i outside HANDLER is ignored. mask_we_i takes effect the next cycle in any state.
//  Registered outputs: interception_o, pc_sel_o, ack_o are decoded from registered state,
//   so there is no combinational path from inputs.
// CONFIGURATION
//  INT_ROUND_ROBIN_EN defined: the hardware winner is chosen round-robin, starting from the index
//   after the last serviced source (pointer resets to 0, advances only on a hardware TAKE).
//  INT_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins.
//  Software priority over hardware holds in both modes.
// STRUCTURE
//  int_defs.vh: state encodings (IDLE..RETURN), PC_SEL_NORM/VEC/EPC codes, CAUSE_W = 5, SW cause bit.
//  Sub-module int_arbiter: combinational request vector + last pointer -> one-hot grant and index;
//   contains the INT_ROUND_ROBIN_EN mux.
//  Top-level int_sequencer: edge detect, pending/enable regs, FSM, EPC/cause regs.
// TESTING
//  1. Enable 4'hF. Edge on irq_i[2] with pc_id_i = 16'h0123, safe point.
//     -> TAKE next cycle; epc_o = 16'h0123, cause_o = 5'h02, ack_o = 4'b0100;
//        pc_sel_o = 01 for 1 cycle, then HANDLER.
//  2. sw_int_i with sw_code_i = 4'hA together with irq_i[0] edge, enable = 0.
//     -> cause_o = 5'h1A; pending[0] stays set; taken (if enabled) only after ERET/RETURN.
//  3. Pending request while br_in_ex_i = 1 or stall_i = 1 for 3 cycles.
//     -> no TAKE until the first cycle with a safe point; epc_o = PC of that cycle.
//  4. ERET in HANDLER -> pc_sel_o = 10 with epc_o unchanged for 1 cycle, then IDLE.
//     ERET in IDLE -> no pc_sel_o change.
//  5. Fixed priority: irq 1 and 3 pending -> 1 served, then 3.
//     Round-robin (INT_ROUND_ROBIN_EN): after serving 1, sources 1 and 3 both pending again -> 3 served first.
//  6. RST asserted during VECTOR -> all outputs 0 immediately, without waiting for a clock edge;
//     a fresh edge after reset is served normally.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// ============================================================================
//  Module      : int_sequencer_pkg
//  Description : Shared state encodings and output codes for int_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TAKE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_e;

    localparam logic [1:0] c_pc_sel_norm = 2'b00;
    localparam logic [1:0] c_pc_sel_vec  = 2'b01;
    localparam logic [1:0] c_pc_sel_epc  = 2'b10;

    localparam int c_cause_w      = 5;
    localparam int c_cause_sw_bit = 4;

endpackage

`default_nettype wire

// File: rtl/int_sequencer_arbiter.sv
// ============================================================================
//  Module      : int_sequencer_arbiter
//  Description : Combinational hardware-interrupt arbiter. Fixed priority
//                (lowest index) by default; round-robin from ptr_i when
//                INT_ROUND_ROBIN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sequencer_arbiter #(
    parameter int NSRC = 4,
    parameter int IW   = 2
) (
    input  logic [NSRC-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NSRC-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

`ifdef INT_ROUND_ROBIN_EN
    always_comb begin
        int j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Scan starting at the pointer, wrapping at NSRC.
        for (int k = 0; k < NSRC; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NSRC) begin
                j = j - NSRC;
            end
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr_i;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                grant_o    = '0;
                grant_o[k] = 1'b1;
                idx_o      = IW'(k);
                valid_o    = 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/int_sequencer.sv
// ============================================================================
//  Module      : int_sequencer
//  Description : Interrupt sequencer: edge capture, enable mask, arbitration,
//                safe-point take, vector/EPC PC redirection.
//                Optional macro INT_ROUND_ROBIN_EN selects round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int          NSRC     = 4,
    parameter logic [15:0] VEC_BASE = 16'h0008
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NSRC-1:0]      irq_i,
    input  logic                 mask_we_i,
    input  logic [NSRC-1:0]      mask_d_i,
    input  logic                 sw_int_i,
    input  logic [3:0]           sw_code_i,
    input  logic                 id_valid_i,
    input  logic                 stall_i,
    input  logic                 br_in_ex_i,
    input  logic [15:0]          pc_id_i,
    input  logic                 eret_i,
    output logic                 interception_o,
    output logic [15:0]          epc_o,
    output logic [c_cause_w-1:0] cause_o,
    output logic [15:0]          vector_o,
    output logic [1:0]           pc_sel_o,
    output logic [NSRC-1:0]      ack_o,
    output logic                 busy_o
);

    localparam int c_iw = $clog2(NSRC);

    state_e                 state_q, state_d;
    logic [NSRC-1:0]        irq_q, irq_d;
    logic [NSRC-1:0]        pending_q, pending_d;
    logic [NSRC-1:0]        enable_q, enable_d;
    logic [NSRC-1:0]        ack_q, ack_d;
    logic [c_iw-1:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]            epc_q, epc_d;
    logic [c_cause_w-1:0]   cause_q, cause_d;
    logic                   intercept_q, intercept_d;
    logic [1:0]             pc_sel_q, pc_sel_d;

    logic [NSRC-1:0]        w_grant;
    logic [c_iw-1:0]        w_idx;
    logic                   w_hw_any;
    logic                   w_safe;

    int_sequencer_arbiter #(
        .NSRC (NSRC),
        .IW   (c_iw)
    ) u_arbiter (
        .req_i   (pending_q & enable_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .valid_o (w_hw_any)
    );

    assign w_safe = id_valid_i & ~stall_i & ~br_in_ex_i;

    always_comb begin
        irq_d       = irq_i;
        // A fresh edge beats the acknowledge clear in the same cycle.
        pending_d   = (pending_q & ~ack_q) | (irq_i & ~irq_q);
        enable_d    = mask_we_i ? mask_d_i : enable_q;
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        rr_ptr_d    = rr_ptr_q;
        intercept_d = 1'b0;
        pc_sel_d    = c_pc_sel_norm;
        ack_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if ((sw_int_i || w_hw_any) && w_safe) begin
                    state_d     = ST_TAKE;
                    epc_d       = pc_id_i;
                    intercept_d = 1'b1;
                    if (sw_int_i) begin
                        cause_d = {1'b1, sw_code_i};
                    end else begin
                        cause_d  = {1'b0, 4'(w_idx)};
                        ack_d    = w_grant;
                        rr_ptr_d = (w_idx == c_iw'(NSRC - 1)) ? '0 : w_idx + 1'b1;
                    end
                end
            end
            ST_TAKE: begin
                state_d  = ST_VECTOR;
                pc_sel_d = c_pc_sel_vec;
            end
            ST_VECTOR: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret_i) begin
                    state_d  = ST_RETURN;
                    pc_sel_d = c_pc_sel_epc;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            ack_q       <= '0;
            rr_ptr_q    <= '0;
            epc_q       <= '0;
            cause_q     <= '0;
            intercept_q <= 1'b0;
            pc_sel_q    <= c_pc_sel_norm;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            ack_q       <= ack_d;
            rr_ptr_q    <= rr_ptr_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            intercept_q <= intercept_d;
            pc_sel_q    <= pc_sel_d;
        end
    end

    assign interception_o = intercept_q;
    assign epc_o          = epc_q;
    assign cause_o        = cause_q;
    assign vector_o       = VEC_BASE;
    assign pc_sel_o       = pc_sel_q;
    assign ack_o          = ack_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// ============================================================================
//  Module      : tb_int_sequencer
//  Description : Directed self-checking bench for int_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_sequencer;

    logic        CLK;
    logic        RST;
    logic [3:0]  irq_i;
    logic        mask_we_i;
    logic [3:0]  mask_d_i;
    logic        sw_int_i;
    logic [3:0]  sw_code_i;
    logic        id_valid_i;
    logic        stall_i;
    logic        br_in_ex_i;
    logic [15:0] pc_id_i;
    logic        eret_i;
    logic        interception_o;
    logic [15:0] epc_o;
    logic [4:0]  cause_o;
    logic [15:0] vector_o;
    logic [1:0]  pc_sel_o;
    logic [3:0]  ack_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    int_sequencer #(
        .NSRC     (4),
        .VEC_BASE (16'h0008)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .irq_i          (irq_i),
        .mask_we_i      (mask_we_i),
        .mask_d_i       (mask_d_i),
        .sw_int_i       (sw_int_i),
        .sw_code_i      (sw_code_i),
        .id_valid_i     (id_valid_i),
        .stall_i        (stall_i),
        .br_in_ex_i     (br_in_ex_i),
        .pc_id_i        (pc_id_i),
        .eret_i         (eret_i),
        .interception_o (interception_o),
        .epc_o          (epc_o),
        .cause_o        (cause_o),
        .vector_o       (vector_o),
        .pc_sel_o       (pc_sel_o),
        .ack_o          (ack_o),
        .busy_o         (busy_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we_i = 1'b1;
        mask_d_i  = m;
        tick();
        mask_we_i = 1'b0;
    endtask

    // Called right after the TAKE cycle has been observed; ends back in IDLE.
    task automatic drain(input string tag);
        tick();
        chk({tag, "_vec_sel"}, 32'(pc_sel_o), 32'h1);
        tick();
        chk({tag, "_hdl_sel"}, 32'(pc_sel_o), 32'h0);
        eret_i = 1'b1;
        tick();
        chk({tag, "_ret_sel"}, 32'(pc_sel_o), 32'h2);
        eret_i = 1'b0;
        tick();
        chk({tag, "_idle_busy"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        RST        = 1'b1;
        irq_i      = '0;
        mask_we_i  = 1'b0;
        mask_d_i   = '0;
        sw_int_i   = 1'b0;
        sw_code_i  = '0;
        id_valid_i = 1'b0;
        stall_i    = 1'b0;
        br_in_ex_i = 1'b0;
        pc_id_i    = '0;
        eret_i     = 1'b0;
        tick();
        tick();
        chk("rst_intercept", 32'(interception_o), 32'h0);
        chk("rst_pc_sel",    32'(pc_sel_o),       32'h0);
        chk("rst_ack",       32'(ack_o),          32'h0);
        chk("rst_epc",       32'(epc_o),          32'h0);
        chk("rst_cause",     32'(cause_o),        32'h0);
        chk("rst_busy",      32'(busy_o),         32'h0);
        chk("vector",        32'(vector_o),       32'h8);
        RST = 1'b0;
        tick();

        // 1: hardware edge on source 2 at a safe point
        set_mask(4'hF);
        id_valid_i = 1'b1;
        pc_id_i    = 16'h0123;
        irq_i      = 4'b0100;
        tick();
        chk("t1_no_take_yet", 32'(interception_o), 32'h0);
        tick();
        chk("t1_intercept", 32'(interception_o), 32'h1);
        chk("t1_epc",       32'(epc_o),          32'h0123);
        chk("t1_cause",     32'(cause_o),        32'h02);
        chk("t1_ack",       32'(ack_o),          32'h4);
        chk("t1_busy",      32'(busy_o),         32'h1);
        tick();
        chk("t1_vec_sel",   32'(pc_sel_o),       32'h1);
        chk("t1_vec_ack",   32'(ack_o),          32'h0);
        chk("t1_vec_int",   32'(interception_o), 32'h0);
        tick();
        chk("t1_hdl_sel",   32'(pc_sel_o),       32'h0);
        chk("t1_hdl_busy",  32'(busy_o),         32'h1);

        // 4: ERET in HANDLER, then ERET in IDLE
        pc_id_i = 16'h0777;
        eret_i  = 1'b1;
        tick();
        chk("t4_ret_sel", 32'(pc_sel_o), 32'h2);
        chk("t4_ret_epc", 32'(epc_o),    32'h0123);
        eret_i = 1'b0;
        tick();
        chk("t4_idle_sel",  32'(pc_sel_o), 32'h0);
        chk("t4_idle_busy", 32'(busy_o),   32'h0);
        tick();
        chk("t4_pending_cleared", 32'(interception_o), 32'h0);
        irq_i  = '0;
        eret_i = 1'b1;
        tick();
        chk("t4_eret_idle_sel",  32'(pc_sel_o), 32'h0);
        chk("t4_eret_idle_busy", 32'(busy_o),   32'h0);
        eret_i = 1'b0;
        tick();

        // 2: software INT beats a masked hardware edge
        set_mask(4'h0);
        pc_id_i   = 16'h0200;
        sw_int_i  = 1'b1;
        sw_code_i = 4'hA;
        irq_i     = 4'b0001;
        tick();
        chk("t2_intercept", 32'(interception_o), 32'h1);
        chk("t2_cause",     32'(cause_o),        32'h1A);
        chk("t2_ack",       32'(ack_o),          32'h0);
        chk("t2_epc",       32'(epc_o),          32'h0200);
        sw_int_i = 1'b0;
        tick();
        chk("t2_vec_sel", 32'(pc_sel_o), 32'h1);
        set_mask(4'hF);
        tick();
        chk("t2_hdl_no_take", 32'(interception_o), 32'h0);
        chk("t2_hdl_busy",    32'(busy_o),         32'h1);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        tick();
        chk("t2_idle_busy", 32'(busy_o), 32'h0);
        tick();
        chk("t2_hw_intercept", 32'(interception_o), 32'h1);
        chk("t2_hw_cause",     32'(cause_o),        32'h00);
        chk("t2_hw_ack",       32'(ack_o),          32'h1);
        drain("t2");
        irq_i = '0;

        // 3: request held off by branch/stall/bubble for 3 cycles
        br_in_ex_i = 1'b1;
        pc_id_i    = 16'h0300;
        irq_i      = 4'b1000;
        tick();
        tick();
        chk("t3_wait_br", 32'(interception_o), 32'h0);
        br_in_ex_i = 1'b0;
        stall_i    = 1'b1;
        pc_id_i    = 16'h0310;
        tick();
        chk("t3_wait_stall", 32'(interception_o), 32'h0);
        stall_i    = 1'b0;
        id_valid_i = 1'b0;
        pc_id_i    = 16'h0320;
        tick();
        chk("t3_wait_bubble", 32'(interception_o), 32'h0);
        id_valid_i = 1'b1;
        pc_id_i    = 16'h0340;
        tick();
        chk("t3_intercept", 32'(interception_o), 32'h1);
        chk("t3_epc",       32'(epc_o),          32'h0340);
        chk("t3_cause",     32'(cause_o),        32'h03);
        drain("t3");
        irq_i = '0;
        tick();

        // 5a: sources 1 and 3 pending together -> 1 then 3
        id_valid_i = 1'b0;
        irq_i      = 4'b1010;
        tick();
        tick();
        id_valid_i = 1'b1;
        tick();
        chk("t5a_first_cause", 32'(cause_o), 32'h01);
        chk("t5a_first_ack",   32'(ack_o),   32'h2);
        irq_i = '0;
        drain("t5a1");
        tick();
        chk("t5a_second_cause", 32'(cause_o), 32'h03);
        chk("t5a_second_ack",   32'(ack_o),   32'h8);
        drain("t5a2");

        // 5b: after serving 1, both 1 and 3 pending again
        irq_i = 4'b1010;
        tick();
        tick();
        chk("t5b_first_cause", 32'(cause_o), 32'h01);
        irq_i = '0;
        tick();
        tick();
        irq_i = 4'b0010;
        tick();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        tick();
        tick();
`ifdef INT_ROUND_ROBIN_EN
        chk("t5b_second_cause", 32'(cause_o), 32'h03);
`else
        chk("t5b_second_cause", 32'(cause_o), 32'h01);
`endif
        drain("t5b2");
        tick();
`ifdef INT_ROUND_ROBIN_EN
        chk("t5b_third_cause", 32'(cause_o), 32'h01);
`else
        chk("t5b_third_cause", 32'(cause_o), 32'h03);
`endif
        drain("t5b3");
        irq_i = '0;
        tick();

        // 6: asynchronous reset in VECTOR
        pc_id_i = 16'h0400;
        irq_i   = 4'b0100;
        tick();
        tick();
        chk("t6_take", 32'(interception_o), 32'h1);
        tick();
        chk("t6_vec_sel", 32'(pc_sel_o), 32'h1);
        #2;
        RST   = 1'b1;
        irq_i = '0;
        #1;
        chk("t6_async_sel",   32'(pc_sel_o), 32'h0);
        chk("t6_async_busy",  32'(busy_o),   32'h0);
        chk("t6_async_epc",   32'(epc_o),    32'h0);
        chk("t6_async_cause", 32'(cause_o),  32'h0);
        tick();
        RST = 1'b0;
        tick();
        pc_id_i = 16'h0500;
        irq_i   = 4'b0001;
        tick();
        tick();
        chk("t6_masked_after_rst", 32'(interception_o), 32'h0);
        set_mask(4'hF);
        tick();
        chk("t6_fresh_take",  32'(interception_o), 32'h1);
        chk("t6_fresh_cause", 32'(cause_o),        32'h00);
        chk("t6_fresh_epc",   32'(epc_o),          32'h0500);
        chk("t6_fresh_ack",   32'(ack_o),          32'h1);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
